bnn_mlp_core: RTL

//  Parametrised two-layer binary MLP: N_IN -> N_HID -> N_OUT (XNOR-popcount with threshold activation).

---
 rtl/bnn_mlp_core_if.sv | 51 +++++
 rtl/bnn_mlp_core.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_mlp_core_if.sv
// -----------------------------------------------------------------------------
// bnn_mlp_core_if
//   Handshake bundle for the binary MLP core: the inference input stream, the
//   registered result/debug outputs and the nibble weight loader.
//
//   Signals (direction seen from the core, i.e. the slave modport):
//     in_valid   in   1      in_data is valid
//     in_ready   out  1      core can accept an input vector this cycle
//     in_data    in   N_IN   binary input vector
//     out_valid  out  1      one-cycle pulse, out_data updated the same cycle
//     out_data   out  N_OUT  layer-2 activations, held between pulses
//     hid_data   out  N_HID  registered layer-1 activations (debug)
//     load_start in   1      pulse: (re)start a weight load from word 0
//     load_valid in   1      load_nib is valid
//     load_ready out  1      core is in the load phase
//     load_nib   in   NIB    weight / threshold word
//     load_done  out  1      one-cycle pulse after the last word is written
//
//   Modports: master = driver of the core (pads / testbench), slave = core.
// -----------------------------------------------------------------------------
interface bnn_mlp_core_if #(
    parameter int N_IN  = 8,
    parameter int N_HID = 8,
    parameter int N_OUT = 4,
    parameter int NIB   = 4
);
    // Inference stream
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_data;
    logic             out_valid;
    logic [N_OUT-1:0] out_data;
    logic [N_HID-1:0] hid_data;

    // Weight loader
    logic             load_start;
    logic             load_valid;
    logic             load_ready;
    logic [NIB-1:0]   load_nib;
    logic             load_done;

    modport master (
        output in_valid, in_data, load_start, load_valid, load_nib,
        input  in_ready, out_valid, out_data, hid_data, load_ready, load_done
    );

    modport slave (
        input  in_valid, in_data, load_start, load_valid, load_nib,
        output in_ready, out_valid, out_data, hid_data, load_ready, load_done
    );
endinterface : bnn_mlp_core_if

// File: rtl/bnn_mlp_core.sv
// -----------------------------------------------------------------------------
// bnn_mlp_core
//   Two-layer binary MLP, N_IN -> N_HID -> N_OUT. Every neuron computes
//   popcount(x XNOR w) and fires when the count reaches its threshold
//   (unsigned compare). Weights live in one flat image loaded NIB bits at a
//   time through a valid/ready loader; inference is a two-stage pipeline
//   (hidden layer registered at the accept edge, output layer one edge later),
//   accepting one vector per cycle while not loading.
//
//   Flat weight image:
//     layer-1 neuron h, input bit i   -> W[h*N_IN + i]
//     layer-2 neuron o, hidden bit j  -> W[N_HID*N_IN + o*N_HID + j]
//   Load word k is written to W[k*NIB +: NIB].
//
//   Optional feature, macro BNN_THRESH_LOAD_EN:
//     defined     : N_HID + N_OUT extra words follow the weight image; they
//                   carry the per-neuron thresholds (hidden 0..N_HID-1, then
//                   outputs 0..N_OUT-1), value taken from the low bits.
//     not defined : thresholds are the constants TH1 / TH2, the load ends
//                   after the weight image.
//
//   Ports:
//     clk    in  clock
//     reset  in  asynchronous, active-high reset
//     bus    slave modport of bnn_mlp_core_if (inference + loader handshakes)
// -----------------------------------------------------------------------------
module bnn_mlp_core #(
    parameter int N_IN  = 8,
    parameter int N_HID = 8,
    parameter int N_OUT = 4,
    parameter int NIB   = 4,
    parameter int TH1   = 6,
    parameter int TH2   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    bnn_mlp_core_if.slave        bus
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int W_BITS  = N_HID*N_IN + N_OUT*N_HID;   // flat weight image
    localparam int L2_BASE = N_HID*N_IN;                 // first layer-2 bit
    localparam int N_WW    = W_BITS / NIB;               // weight words
`ifdef BNN_THRESH_LOAD_EN
    localparam int N_WORDS = N_WW + N_HID + N_OUT;       // weights + thresholds
`else
    localparam int N_WORDS = N_WW;
`endif
    localparam int PTR_W   = $clog2(N_WORDS + 1);
    localparam int PC1_W   = $clog2(N_IN + 1);           // layer-1 popcount width
    localparam int PC2_W   = $clog2(N_HID + 1);          // layer-2 popcount width

    typedef enum logic {
        S_IDLE,
        S_LOAD
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic               load_done_q;
    logic [W_BITS-1:0]  w_q;

    logic               v1_q;          // hidden stage holds a fresh result
    logic [N_HID-1:0]   hid_q;
    logic               out_valid_q;
    logic [N_OUT-1:0]   out_q;

    // Effective thresholds seen by the neurons
    logic [PC1_W-1:0]   th1 [N_HID];
    logic [PC2_W-1:0]   th2 [N_OUT];

`ifdef BNN_THRESH_LOAD_EN
    logic [PC1_W-1:0]   th1_q [N_HID];
    logic [PC2_W-1:0]   th2_q [N_OUT];
`endif

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    logic in_acc;
    logic load_acc;
    logic last_word;

    // load_start has priority over an input offered in the same cycle, so the
    // input side is held off combinationally.
    assign bus.in_ready   = (state_q == S_IDLE) && !bus.load_start;
    assign bus.load_ready = (state_q == S_LOAD);

    assign in_acc    = bus.in_valid && bus.in_ready;
    // A restart in the same cycle wins over a word; the word is not taken.
    assign load_acc  = (state_q == S_LOAD) && bus.load_valid && !bus.load_start;
    assign last_word = (ptr_q == PTR_W'(N_WORDS - 1));

    // -------------------------------------------------------------------------
    // Popcount helpers: number of positions where x and w agree
    // -------------------------------------------------------------------------
    function automatic logic [PC1_W-1:0] pop1(input logic [N_IN-1:0] x,
                                              input logic [N_IN-1:0] w);
        logic [PC1_W-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < N_IN; k++) begin
            cnt = cnt + PC1_W'(x[k] ~^ w[k]);
        end
        return cnt;
    endfunction

    function automatic logic [PC2_W-1:0] pop2(input logic [N_HID-1:0] x,
                                              input logic [N_HID-1:0] w);
        logic [PC2_W-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < N_HID; k++) begin
            cnt = cnt + PC2_W'(x[k] ~^ w[k]);
        end
        return cnt;
    endfunction

    // -------------------------------------------------------------------------
    // Threshold source
    // -------------------------------------------------------------------------
    always_comb begin
        for (int h = 0; h < N_HID; h++) begin
`ifdef BNN_THRESH_LOAD_EN
            th1[h] = th1_q[h];
`else
            th1[h] = PC1_W'(TH1);
`endif
        end
        for (int o = 0; o < N_OUT; o++) begin
`ifdef BNN_THRESH_LOAD_EN
            th2[o] = th2_q[o];
`else
            th2[o] = PC2_W'(TH2);
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Neuron arrays (combinational)
    //   Layer 1 works on the incoming vector, layer 2 on the registered hidden
    //   activations; hidden bit j pairs with layer-2 weight bit j.
    // -------------------------------------------------------------------------
    logic [N_HID-1:0] hid_d;
    logic [N_OUT-1:0] out_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional or loop writes it, so no path can leave it unassigned and
        // infer a latch.
        hid_d = '0;
        out_d = '0;
        for (int h = 0; h < N_HID; h++) begin
            hid_d[h] = (pop1(bus.in_data, w_q[h*N_IN +: N_IN]) >= th1[h]);
        end
        for (int o = 0; o < N_OUT; o++) begin
            out_d[o] = (pop2(hid_q, w_q[L2_BASE + o*N_HID +: N_HID]) >= th2[o]);
        end
    end

    // -------------------------------------------------------------------------
    // Loader FSM and weight / threshold storage
    //   IDLE --load_start--> LOAD (pointer cleared)
    //   LOAD --load_start--> LOAD (pointer cleared, written words are kept)
    //   LOAD --last word--> IDLE, load_done pulses in the following cycle
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            load_done_q <= 1'b0;
            // NOTE: the weight image is deliberately part of the reset domain:
            // the core must compute with all-zero weights straight out of
            // reset, so this storage is flops, not an uninitialised RAM.
            w_q         <= '0;
`ifdef BNN_THRESH_LOAD_EN
            for (int h = 0; h < N_HID; h++) th1_q[h] <= PC1_W'(TH1);
            for (int o = 0; o < N_OUT; o++) th2_q[o] <= PC2_W'(TH2);
`endif
        end else begin
            // NOTE: sequential state is always updated with non-blocking
            // assignments so every flop samples pre-edge values, independent
            // of statement and process ordering.
            load_done_q <= 1'b0;
            if (bus.load_start) begin
                state_q <= S_LOAD;
                ptr_q   <= '0;
            end else if (load_acc) begin
                for (int k = 0; k < N_WW; k++) begin
                    if (ptr_q == PTR_W'(k)) begin
                        w_q[k*NIB +: NIB] <= bus.load_nib;
                    end
                end
`ifdef BNN_THRESH_LOAD_EN
                for (int h = 0; h < N_HID; h++) begin
                    if (ptr_q == PTR_W'(N_WW + h)) begin
                        th1_q[h] <= bus.load_nib[PC1_W-1:0];
                    end
                end
                for (int o = 0; o < N_OUT; o++) begin
                    if (ptr_q == PTR_W'(N_WW + N_HID + o)) begin
                        th2_q[o] <= bus.load_nib[PC2_W-1:0];
                    end
                end
`endif
                if (last_word) begin
                    state_q     <= S_IDLE;
                    ptr_q       <= '0;
                    load_done_q <= 1'b1;
                end else begin
                    ptr_q <= ptr_q + PTR_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Inference pipeline
    //   Edge E0 (accept edge) captures the hidden layer, edge E1 captures the
    //   output layer and raises out_valid. Layer-2 weights are read at E1;
    //   a load starting right after an accept only reaches the layer-2 words
    //   many cycles later, so in-flight results use the old layer-2 weights.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q        <= 1'b0;
            hid_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            v1_q        <= in_acc;
            out_valid_q <= v1_q;
            if (in_acc) begin
                hid_q <= hid_d;
            end
            if (v1_q) begin
                out_q <= out_d;
            end
        end
    end

    assign bus.hid_data  = hid_q;
    assign bus.out_data  = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.load_done = load_done_q;

endmodule : bnn_mlp_core
